wb_stage: RTL
=============

# wb_stage

Registered, parametrised writeback stage for the riscy core, sitting between the MEM/WB pipeline register and the register file write port. It selects the writeback source per opcode: ALU result, PC+4 or the memory load response. It aligns and sign/zero-extends load data, and waits for a multi-cycle data-memory response. It also applies backpressure upstream, suppresses writes to x0, flags bad loads and keeps a retired-instruction counter.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- CNT_W, 64: width of retired-instruction counter.
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  MEM/WB slot holds a real instruction.
- in_ready  out  1  stage can accept; combinational, high only in IDLE.
- instr  in  32  full instruction word; opcode [6:0], rd [11:7], funct3 [14:12].
- alu_result  in  XLEN  ALU output; also the load byte address, whose low bits are used.
- pc_p4  in  XLEN  PC+4 of the instruction.
- mem_rvalid  in  1  load data valid this cycle.
- mem_rdata  in  XLEN  raw naturally-aligned memory word.
- rf_we  out  1  register file write enable, one-cycle pulse.
- rf_waddr  out  5  destination register.
- rf_wdata  out  XLEN  write data.
- load_err  out  1  one-cycle pulse; misaligned or illegal-funct3 load retired.
- instret  out  CNT_W  count of retired instructions.

## Operation
Opcode classes:
- ALU source: R 0110011, I 0010011, LUI 0110111, AUIPC 0010111.
- PC+4 source: JAL 1101111, JALR 1100111.
- Memory source: LOAD 0000011.
- No write: B 1100011, STORE 0100011, MEM 0001111, SYS 1110011, all other opcodes.

State machine:
- States are IDLE and WAIT_LOAD.
- IDLE: an accept occurs on in_valid & in_ready. A LOAD accept latches rd, funct3 and alu_result[2:0], then goes to WAIT_LOAD. Any other accept retires the instruction directly and stays in IDLE.
- WAIT_LOAD: in_ready is 0. When mem_rvalid is seen, the load retires and the state returns to IDLE.
- mem_rvalid is ignored in IDLE.

Load extraction:
- Byte offset off = latched addr bits. Use [1:0] for XLEN=32 and [2:0] for XLEN=64.
- LB 000 / LBU 100: byte at off, sign- or zero-extended.
- LH 001 / LHU 101: halfword at off; off[0] must be 0.
- LW 010: word at off; off[1:0] must be 0. Sign-extended when XLEN=64.
- LWU 110 and LD 011: legal only when XLEN=64. LWU needs off[1:0]=0; LD needs off=0.
- Illegal combination (any other funct3, or a misaligned offset): rf_we=0 and rf_wdata=0. load_err pulses, and the load still counts as retired.

Write rules:
- rf_we=1 only for a write-class instruction with rd!=0 and no load error.
- rf_waddr=rd whenever an instruction retires.
- rf_wdata is the selected source, or 0 for no-write classes.

instret:
- Increments by 1 per retired instruction.
- instr==0x00000013 (pipeline bubble NOP) is accepted but neither written nor counted.
- Wraps modulo 2^CNT_W.

## Timing
- All outputs except in_ready are registered.
- Non-load instruction: rf_we, rf_waddr, rf_wdata and the instret update appear in the cycle after the accept edge.
- Load: results appear in the cycle after the edge where mem_rvalid is sampled in WAIT_LOAD. Minimum latency is 2 cycles after accept, since mem_rvalid can first be sampled on the edge after the accept.
- rf_we and load_err are single-cycle pulses. In other cycles rf_waddr and rf_wdata hold their last value.
- Back-to-back non-load accepts are sustained at 1 per cycle. The cycle after a load retires, in_ready is 1 again.
- Reset (asynchronous, any time, including during WAIT_LOAD):
  - State goes to IDLE; in_ready=1.
  - rf_we, rf_waddr, rf_wdata and load_err go to 0; instret goes to 0.
  - A pending load is dropped. A mem_rvalid arriving after reset is ignored.

## Test plan
- addi x5,x0,7 with alu_result=7: rf_we=1, rf_waddr=5, rf_wdata=7 one cycle later; instret=1. Then jal x1 with pc_p4=0x104: rf_wdata=0x104. Then add with rd=x0: rf_we=0, instret still increments.
- LB with addr low bits 2'b11 and mem_rdata=0x80FF_1234 (XLEN=32), mem_rvalid 3 cycles later: in_ready low throughout the wait; rf_wdata=0xFFFF_FF80. With LBU: rf_wdata=0x0000_0080.
- LH at offset 1: load_err pulses, rf_we=0, instret increments. LW at offset 0 with mem_rdata=0xDEAD_BEEF: rf_wdata=0xDEAD_BEEF.
- XLEN=64: LD at offset 0 returns the full word. LW at offset 4 with data 0x8000_0000 in the upper half: rf_wdata=0xFFFF_FFFF_8000_0000. LD at offset 4: load_err pulses.
- STORE, B, SYS, FENCE and the NOP 0x00000013 streamed back-to-back: rf_we stays 0 throughout; instret increases by 4 (NOP excluded).
- Assert rst during WAIT_LOAD, then pulse mem_rvalid: no write occurs, instret=0, in_ready=1. Set CNT_W=4 and retire 17 instructions: instret=1 (wrapped).

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: picks ALU / PC+4 / load data per opcode, aligns and extends loads,
// stalls upstream while a load response is outstanding, and counts retired instructions.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-1:0]  alu_result_i,
  input  logic [XLEN-1:0]  pc_p4_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic             load_err_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam bit IS64 = (XLEN == 64);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t            state_q, state_d;
  logic [4:0]        rd_q, rd_d;
  logic [2:0]        f3_q, f3_d;
  logic [2:0]        off_q, off_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              load_err_q, load_err_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic              accept;
  logic              src_wr;
  logic [XLEN-1:0]   src_data;
  logic [2:0]        off;
  logic [XLEN-1:0]   shifted;
  logic              ld_ok;
  logic [XLEN-1:0]   ld_data;

  assign opcode     = instr_i[6:0];
  assign rd         = instr_i[11:7];
  assign in_ready_o = (state_q == IDLE);
  assign accept     = in_valid_i & in_ready_o;

  // Non-load source selection; no-write classes deliver zero data.
  always_comb begin
    src_wr   = 1'b0;
    src_data = '0;
    case (opcode)
      OP_R, OP_I, OP_LUI, OP_AUIPC: begin
        src_wr   = 1'b1;
        src_data = alu_result_i;
      end
      OP_JAL, OP_JALR: begin
        src_wr   = 1'b1;
        src_data = pc_p4_i;
      end
      default: ;
    endcase
  end

  // Load alignment: shift the requested lane down to bit 0, then extend.
  assign off     = IS64 ? off_q : {1'b0, off_q[1:0]};
  assign shifted = mem_rdata_i >> {off, 3'b000};

  always_comb begin
    ld_ok   = 1'b0;
    ld_data = '0;
    case (f3_q)
      3'b000: begin ld_ok = 1'b1;            ld_data = XLEN'($signed(shifted[7:0]));   end
      3'b100: begin ld_ok = 1'b1;            ld_data = XLEN'(shifted[7:0]);            end
      3'b001: begin ld_ok = ~off[0];         ld_data = XLEN'($signed(shifted[15:0]));  end
      3'b101: begin ld_ok = ~off[0];         ld_data = XLEN'(shifted[15:0]);           end
      3'b010: begin ld_ok = (off[1:0] == 2'b00); ld_data = XLEN'($signed(shifted[31:0])); end
      3'b110: begin ld_ok = IS64 && (off[1:0] == 2'b00); ld_data = XLEN'(shifted[31:0]); end
      3'b011: begin ld_ok = IS64 && (off == 3'b000);     ld_data = shifted;              end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    load_err_d = 1'b0;
    instret_d  = instret_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode == OP_LOAD) begin
            rd_d    = rd;
            f3_d    = instr_i[14:12];
            off_d   = alu_result_i[2:0];
            state_d = WAIT_LOAD;
          end else if (instr_i != NOP) begin
            rf_we_d    = src_wr && (rd != 5'd0);
            rf_waddr_d = rd;
            rf_wdata_d = src_data;
            instret_d  = instret_q + 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid_i) begin
          rf_we_d    = ld_ok && (rd_q != 5'd0);
          rf_waddr_d = rd_q;
          rf_wdata_d = ld_ok ? ld_data : '0;
          load_err_d = ~ld_ok;
          instret_d  = instret_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_q       <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      load_err_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      load_err_q <= load_err_d;
      instret_q  <= instret_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;
  assign load_err_o = load_err_q;
  assign instret_o  = instret_q;

endmodule
